// File: rtl/approx_product_accumulator.sv
// approx_product_accumulator: saturating accumulation of N approximate products into one sum
module approx_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [PROD_W-1:0] product_i,
    input  logic              product_valid_i,
    output logic              product_ready_o,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i,
    output logic              sat_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state, state_nx;
    logic [ACC_W-1:0]   acc, acc_nx;
    logic [LEN_W-1:0]   cnt;
    logic               sat, ovf, beat, last;
    logic [ACC_W:0]     wide;

    assign product_ready_o = (state == ACCUM);
    assign sum_valid_o     = (state == HOLD);
    assign busy_o          = (state != IDLE);
    assign beat            = product_valid_i && product_ready_o;
    assign last            = beat && (cnt == LEN_W'(1));
    assign wide            = {1'b0, acc} + (ACC_W+1)'(product_i);
    assign ovf             = wide[ACC_W];
    assign acc_nx          = ovf ? '1 : wide[ACC_W-1:0];

    // next-state decode; start is only honoured in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = (len_i != '0) ? ACCUM : HOLD;
            ACCUM:   if (last) state_nx = HOLD;
            HOLD:    if (sum_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register plus accumulator datapath and registered result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            sum_o <= '0;
            sat_o <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start_i) begin
                acc <= '0;
                sat <= 1'b0;
                cnt <= len_i;
                if (len_i == '0) begin
                    sum_o <= '0;
                    sat_o <= 1'b0;
                end
            end
            if (beat) begin
                acc <= acc_nx;
                sat <= sat | ovf;
                cnt <= cnt - LEN_W'(1);
                if (last) begin
                    sum_o <= acc_nx;
                    sat_o <= sat | ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_approx_product_accumulator.sv
// tb_approx_product_accumulator: randomized scoreboard bench for the saturating product accumulator
module tb_approx_product_accumulator;
    localparam int PROD_W = 16;
    localparam int ACC_W  = 17;
    localparam int LEN_W  = 8;
    localparam longint MAX = (64'd1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [LEN_W-1:0]  len_i = '0;
    logic [PROD_W-1:0] product_i = '0;
    logic              product_valid_i = 1'b0;
    logic              product_ready_o;
    logic [ACC_W-1:0]  sum_o;
    logic              sum_valid_o;
    logic              sum_ready_i = 1'b0;
    logic              sat_o;
    logic              busy_o;

    int checks = 0;
    int failures = 0;
    int ready_mode = 1;
    logic [ACC_W:0]    exp_q[$];
    logic [PROD_W-1:0] prods[$];

    logic             pv = 1'b0, phs = 1'b0, psat = 1'b0, hs;
    logic [ACC_W-1:0] psum = '0;
    logic [ACC_W:0]   e;

    approx_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .product_i(product_i), .product_valid_i(product_valid_i), .product_ready_o(product_ready_o),
        .sum_o(sum_o), .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i),
        .sat_o(sat_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // expected result: true sum clamped to the accumulator range, sat if it ever exceeded it
    function automatic logic [ACC_W:0] model();
        longint total = 0;
        foreach (prods[i]) total += longint'(prods[i]);
        return (total > MAX) ? {1'b1, ACC_W'(MAX)} : {1'b0, ACC_W'(total)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 300) begin
            cyc();
            n++;
        end
        if (busy_o) check("idle_timeout", busy_o, 0);
    endtask

    // hold_mode: 0 none, 1 pulse start after 5 HOLD cycles, 2 pulse start on the handshake cycle
    task automatic run_txn(input int gap_mode, input int hold_mode);
        int g, n;
        logic ok;
        wait_idle();
        exp_q.push_back(model());
        start_i = 1'b1;
        len_i = LEN_W'(prods.size());
        cyc();
        start_i = 1'b0;
        len_i = LEN_W'($urandom);
        if (prods.size() == 0) begin
            check("len0_valid", sum_valid_o, 1);
            check("len0_ready", product_ready_o, 0);
        end else begin
            check("first_ready", product_ready_o, 1);
        end
        foreach (prods[i]) begin
            g = (gap_mode == 1) ? int'(i > 0) :
                (gap_mode == 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            repeat (g) begin
                product_valid_i = 1'b0;
                product_i = PROD_W'($urandom);
                cyc();
            end
            product_valid_i = 1'b1;
            product_i = prods[i];
            n = 0;
            do begin
                ok = product_ready_o;
                cyc();
                n++;
            end while (!ok && n < 50);
            if (!ok) check("beat_timeout", ok, 1);
        end
        product_valid_i = 1'b0;
        if (prods.size() != 0) check("valid_latency", sum_valid_o, 1);
        if (hold_mode == 1) begin
            repeat (5) cyc();
            start_i = 1'b1;
            len_i = 7;
            cyc();
            start_i = 1'b0;
            check("hold_busy", busy_o, 1);
            check("hold_valid", sum_valid_o, 1);
        end else if (hold_mode == 2) begin
            start_i = 1'b1;
            len_i = 3;
            cyc();
            start_i = 1'b0;
            check("hs_start_ignored", busy_o, 0);
        end
    endtask

    // consumer side: ready pattern selected by ready_mode (0 random, 1 high, 2 low)
    initial forever begin
        @(posedge clk);
        #1;
        sum_ready_i = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    // monitor: checks held results for stability and pops the scoreboard on each transfer
    initial forever begin
        @(negedge clk);
        if (!rst_ni) begin
            pv = 1'b0;
            phs = 1'b0;
            continue;
        end
        if (sum_valid_o && pv && !phs) begin
            check("sum_stable", sum_o, psum);
            check("sat_stable", sat_o, psat);
        end
        hs = sum_valid_o && sum_ready_i;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sum", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sum", sum_o, e[ACC_W-1:0]);
                check("sat", sat_o, e[ACC_W]);
            end
        end
        pv = sum_valid_o;
        phs = hs;
        psum = sum_o;
        psat = sat_o;
    end

    initial begin
        int n, sel;
        repeat (2) cyc();
        check("rst_sum", sum_o, 0);
        check("rst_valid", sum_valid_o, 0);
        check("rst_ready", product_ready_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        cyc();
        prods = {16'h1A0A, 16'h0121, 16'h0E1C};
        run_txn(0, 0);
        prods = {};
        run_txn(0, 0);
        prods = {16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_txn(0, 0);
        prods = {16'h0001};
        run_txn(0, 0);
        wait_idle();
        ready_mode = 2;
        prods = {};
        repeat (4) prods.push_back(PROD_W'($urandom));
        run_txn(1, 1);
        ready_mode = 1;
        wait_idle();
        repeat (3) cyc();
        check("idle_after_hs", busy_o, 0);
        prods = {16'h0055};
        run_txn(0, 2);
        wait_idle();
        start_i = 1'b1;
        len_i = 4;
        cyc();
        start_i = 1'b0;
        product_valid_i = 1'b1;
        product_i = 16'h1111;
        cyc();
        cyc();
        product_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_sum", sum_o, 0);
        check("mid_rst_valid", sum_valid_o, 0);
        check("mid_rst_ready", product_ready_o, 0);
        check("mid_rst_sat", sat_o, 0);
        check("mid_rst_busy", busy_o, 0);
        repeat (2) cyc();
        rst_ni = 1'b1;
        cyc();
        prods = {16'h0400};
        run_txn(0, 0);
        ready_mode = 0;
        repeat (25) begin
            n = $urandom_range(0, 9);
            prods = {};
            repeat (n) begin
                sel = $urandom_range(0, 3);
                prods.push_back(sel == 0 ? (16'hF000 | PROD_W'($urandom)) :
                                sel == 1 ? PROD_W'($urandom_range(0, 255)) : PROD_W'($urandom));
            end
            run_txn(2, 0);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            cyc();
            n++;
        end
        check("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
